// File: rtl/uart_rx_os16_if.sv
// Line-side and byte-side signals of the 16x-oversampling UART receiver.
// slave = receiver, master = line driver / byte consumer.
interface uart_rx_os16_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 baud_tick;
  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_full;
  logic                 rx_ack;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun;
  logic                 rx_busy;

  modport master (
    output baud_tick, rx_in, rx_ack,
    input  rx_data, rx_full, rx_valid, frame_err, overrun, rx_busy
  );

  modport slave (
    input  baud_tick, rx_in, rx_ack,
    output rx_data, rx_full, rx_valid, frame_err, overrun, rx_busy
  );
endinterface

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver: oversampled start/data/stop recovery with a full/ack
// holding register, framing-error pulse and sticky overrun.
module uart_rx_os16 #(
  parameter int unsigned OS_RATE     = 16,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           reset,
  uart_rx_os16_if.slave bus
);
  localparam int unsigned OS_W  = $clog2(OS_RATE);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OS_RATE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OS_RATE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [OS_W-1:0]        os_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   full_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   ovr_q;
  logic                   busy_q;
  logic                   rx_s;

  // Metastability guard; resets to the idle line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx_in};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      os_q    <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      // A commit later in this block overrides the ack's clear of rx_full.
      if (bus.rx_ack && full_q) begin
        full_q <= 1'b0;
        ovr_q  <= 1'b0;
      end
      if (bus.baud_tick) begin
        case (state_q)
          IDLE: begin
            if (!rx_s) begin
              state_q <= START;
              os_q    <= '0;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            os_q <= os_q + OS_W'(1);
            if (os_q == OS_HALF) begin
              if (!rx_s) begin
                state_q <= DATA;
                os_q    <= '0;
                idx_q   <= '0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          DATA: begin
            os_q <= os_q + OS_W'(1);
            if (os_q == OS_LAST) begin
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              if (idx_q == IDX_LAST) state_q <= STOP;
              else                   idx_q   <= idx_q + IDX_W'(1);
            end
          end
          STOP: begin
            os_q <= os_q + OS_W'(1);
            if (os_q == OS_LAST) begin
              state_q <= rx_s ? IDLE : BREAK;
              busy_q  <= !rx_s;
              if (!rx_s) begin
                ferr_q <= 1'b1;
              end else if (!full_q || bus.rx_ack) begin
                data_q  <= shift_q;
                full_q  <= 1'b1;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end
          end
          BREAK: begin
            if (rx_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_full   = full_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.rx_busy   = busy_q;
endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: table of frames, hand sequences for corner cases,
// and randomized +/-3% bit-rate frames against a holding-register model.
module tb_uart_rx_os16;
  localparam int unsigned TD         = 4;
  localparam int unsigned BCLK       = 16 * TD;
  localparam int unsigned STOP_TICKS = 8 + 16 * 9;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       ack;
    logic [7:0] exp_data;
    logic       exp_full;
    int         exp_dv;
    int         exp_fe;
    logic       exp_ovr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned pcount = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          valid_cnt = 0;
  int          fe_cnt = 0;
  int          busy_cnt = 0;
  int unsigned last_valid_pc = 0;

  uart_rx_os16_if #(.DATA_BITS(8)) bus ();

  uart_rx_os16 #(.OS_RATE(16), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcount <= pcount + 1;

  // baud_tick is high for posedges whose number is a multiple of TD
  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      bus.baud_tick = ((pcount + 1) % TD) == 0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.rx_valid) begin
        valid_cnt++;
        last_valid_pc = pcount;
      end
      if (bus.frame_err) fe_cnt++;
      if (bus.rx_busy) busy_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bclk);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx_in = f[i];
      repeat (bclk) @(negedge clk);
    end
  endtask

  task automatic pulse_ack();
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
  endtask

  // Start edge driven after posedge n0 reaches rx_s two flops later; the
  // first tick on or after posedge n0+3 detects it, the stop sample is 152 ticks on.
  function automatic int unsigned commit_pc(input int unsigned n0);
    int unsigned det;
    det = ((n0 + 3 + TD - 1) / TD) * TD;
    return det + STOP_TICKS * TD;
  endfunction

  vec_t        vecs[7];
  int          v0, f0, b0, guard, bclk;
  int unsigned n0, pc;
  logic [31:0] got0, got1;
  logic [9:0]  fr;
  logic [7:0]  m_data, rb;
  logic        m_full, m_ovr;
  int          m_dv;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1, 0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 0, 1, 1'b0};
    vecs[2] = '{8'h12, 1'b1, 1'b0, 8'h12, 1'b1, 1, 0, 1'b0};
    vecs[3] = '{8'h34, 1'b1, 1'b0, 8'h12, 1'b1, 0, 0, 1'b1};
    vecs[4] = '{8'h77, 1'b1, 1'b1, 8'h12, 1'b1, 0, 0, 1'b1};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1, 0, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1, 0, 1'b0};

    reset = 1'b1;
    bus.rx_in = 1'b1;
    bus.rx_ack = 1'b0;
    idle(5);
    check("rst_data", bus.rx_data, 0);
    check("rst_full", bus.rx_full, 0);
    check("rst_valid", bus.rx_valid, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_ovr", bus.overrun, 0);
    check("rst_busy", bus.rx_busy, 0);
    reset = 1'b0;
    idle(10);

    for (int i = 0; i < 7; i++) begin
      v0 = valid_cnt; f0 = fe_cnt; n0 = pcount;
      send_frame(vecs[i].data, vecs[i].stop_bit, BCLK);
      bus.rx_in = 1'b1;
      idle(2 * BCLK);
      check($sformatf("vec%0d_data", i), bus.rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_full", i), bus.rx_full, vecs[i].exp_full);
      check($sformatf("vec%0d_valid_pulses", i), valid_cnt - v0, vecs[i].exp_dv);
      check($sformatf("vec%0d_ferr_pulses", i), fe_cnt - f0, vecs[i].exp_fe);
      check($sformatf("vec%0d_ovr", i), bus.overrun, vecs[i].exp_ovr);
      if (vecs[i].exp_dv != 0)
        check($sformatf("vec%0d_valid_cycle", i), last_valid_pc, commit_pc(n0));
      if (vecs[i].ack) begin
        pulse_ack();
        check($sformatf("vec%0d_ack_full", i), bus.rx_full, 0);
        check($sformatf("vec%0d_ack_ovr", i), bus.overrun, 0);
      end
    end

    // Five-tick glitch: busy for exactly the 8-tick start qualification
    v0 = valid_cnt; f0 = fe_cnt; b0 = busy_cnt;
    bus.rx_in = 1'b0;
    idle(5 * TD);
    bus.rx_in = 1'b1;
    idle(300);
    check("glitch_busy_cycles", busy_cnt - b0, 8 * TD);
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_ferr", fe_cnt - f0, 0);
    check("glitch_busy_end", bus.rx_busy, 0);

    // Framing error followed by a long break
    pulse_ack();
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, BCLK);
    idle(40 * BCLK);
    check("break_busy", bus.rx_busy, 1);
    bus.rx_in = 1'b1;
    idle(2 * BCLK);
    check("break_ferr_pulses", fe_cnt - f0, 1);
    check("break_full", bus.rx_full, 0);
    check("break_busy_end", bus.rx_busy, 0);
    send_frame(8'h11, 1'b1, BCLK);
    idle(BCLK);
    check("after_break_data", bus.rx_data, 8'h11);
    check("after_break_full", bus.rx_full, 1);

    // Overrun, ack, then ack landing exactly on the commit cycle
    send_frame(8'h9A, 1'b1, BCLK);
    idle(BCLK);
    check("ovr_set", bus.overrun, 1);
    check("ovr_data_kept", bus.rx_data, 8'h11);
    pulse_ack();
    check("ovr_ack_clear", bus.overrun, 0);
    check("ovr_ack_full", bus.rx_full, 0);
    send_frame(8'h12, 1'b1, BCLK);
    idle(BCLK);
    v0 = valid_cnt; n0 = pcount;
    fork
      send_frame(8'h56, 1'b1, BCLK);
      begin
        pc = commit_pc(n0);
        while (pcount < pc - 1) @(negedge clk);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
      end
    join
    idle(BCLK);
    check("simul_ack_data", bus.rx_data, 8'h56);
    check("simul_ack_full", bus.rx_full, 1);
    check("simul_ack_ovr", bus.overrun, 0);
    check("simul_ack_valid", valid_cnt - v0, 1);

    // Back-to-back frames with no idle gap, consumer acking each byte
    pulse_ack();
    v0 = valid_cnt; f0 = fe_cnt;
    got0 = 32'hDEAD; got1 = 32'hDEAD;
    fork
      begin
        send_frame(8'h00, 1'b1, BCLK);
        send_frame(8'hFF, 1'b1, BCLK);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          guard = 0;
          while (valid_cnt == v0 + k && guard < 2000) begin
            @(negedge clk);
            guard++;
          end
          if (guard < 2000) begin
            if (k == 0) got0 = 32'(bus.rx_data);
            else        got1 = 32'(bus.rx_data);
            pulse_ack();
          end
        end
      end
    join
    idle(BCLK);
    check("b2b_first", got0, 32'h00);
    check("b2b_second", got1, 32'hFF);
    check("b2b_valid_pulses", valid_cnt - v0, 2);
    check("b2b_ferr", fe_cnt - f0, 0);
    check("b2b_ovr", bus.overrun, 0);

    // Reset in the middle of data bit 3 of 0x77
    bus.rx_in = 1'b1;
    send_frame(8'hC3, 1'b1, BCLK);
    idle(BCLK);
    fr = {1'b1, 8'h77, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.rx_in = fr[i];
      idle(i == 4 ? BCLK / 2 : BCLK);
    end
    reset = 1'b1;
    #1;
    check("midrst_data", bus.rx_data, 0);
    check("midrst_full", bus.rx_full, 0);
    check("midrst_valid", bus.rx_valid, 0);
    check("midrst_ferr", bus.frame_err, 0);
    check("midrst_ovr", bus.overrun, 0);
    check("midrst_busy", bus.rx_busy, 0);
    bus.rx_in = 1'b1;
    idle(4);
    reset = 1'b0;
    idle(2 * BCLK);
    send_frame(8'h81, 1'b1, BCLK);
    idle(BCLK);
    check("post_rst_data", bus.rx_data, 8'h81);
    check("post_rst_full", bus.rx_full, 1);

    // Random bytes at +/-3% bit rate, random acks between frames
    m_data = 8'h81; m_full = 1'b1; m_ovr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        if (m_full) begin
          m_full = 1'b0;
          m_ovr  = 1'b0;
        end
      end
      rb = 8'($urandom);
      bclk = int'($urandom_range(62, 66));
      v0 = valid_cnt; f0 = fe_cnt;
      send_frame(rb, 1'b1, bclk);
      m_dv = 0;
      if (!m_full) begin
        m_data = rb;
        m_full = 1'b1;
        m_dv   = 1;
      end else begin
        m_ovr = 1'b1;
      end
      idle(int'($urandom_range(1, 64)));
      check($sformatf("rnd%0d_data", i), bus.rx_data, m_data);
      check($sformatf("rnd%0d_full", i), bus.rx_full, m_full);
      check($sformatf("rnd%0d_ovr", i), bus.overrun, m_ovr);
      check($sformatf("rnd%0d_valid", i), valid_cnt - v0, m_dv);
      check($sformatf("rnd%0d_ferr", i), fe_cnt - f0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- UART receive front end for the memory-mapped peripheral block.
- Recovers 8N1 serial frames from the asynchronous RX pin using 16x oversampling driven by a baud-tick enable.
- Presents each received byte through a full/ack holding register; the peripheral latches it into its RX data register and sets its receive flag.
- Reports framing errors and overruns.

Parameters:
- OS_RATE, 16, baud_tick pulses per bit period; must be a power of two, at least 8.
- DATA_BITS, 8, data bits per frame, LSB first.
- SYNC_STAGES, 2, number of flops in the rx_in synchronizer; minimum 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- baud_tick  input  1  one-clk-wide enable at OS_RATE x baud.
- rx_in  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  last accepted byte.
- rx_full  output  1  rx_data holds an unacknowledged byte.
- rx_ack  input  1  one-clk pulse: consumer has taken rx_data.
- rx_valid  output  1  one-clk pulse when a new byte is loaded into rx_data.
- frame_err  output  1  one-clk pulse when the stop bit samples 0.
- overrun  output  1  sticky; a frame completed while rx_full=1 and rx_ack=0.
- rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, any time, including mid-frame):
  - FSM returns to IDLE; counters clear.
  - Synchronizer flops are set to 1.
  - rx_data=0, rx_full=0, rx_valid=0, frame_err=0, overrun=0, rx_busy=0.
- Synchronizer: rx_in passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s. Only baud_tick cycles advance the FSM and counters; other clk cycles hold state.
- Counters:
  - os_cnt: log2(OS_RATE) bits, wraps naturally.
  - bit_idx: counts 0..DATA_BITS-1.
  - shift register: DATA_BITS wide, filled LSB first (right shift, new bit enters the MSB).
- FSM states and transitions:
  - IDLE: on a tick with rx_s=0, go to START with os_cnt=0.
  - START: each tick increments os_cnt. At the tick where os_cnt==OS_RATE/2-1:
    - rx_s=0: go to DATA with os_cnt=0, bit_idx=0.
    - rx_s=1: glitch; go to IDLE with no outputs.
  - DATA: each tick increments os_cnt. At os_cnt==OS_RATE-1, sample rx_s into the shift register.
    - If bit_idx==DATA_BITS-1, go to STOP.
    - Otherwise bit_idx++.
  - STOP: at os_cnt==OS_RATE-1, sample rx_s.
    - rx_s=1: commit the frame and go to IDLE.
    - rx_s=0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: stay until a tick sees rx_s=1, then go to IDLE. A held-low line therefore produces exactly one frame_err.
- Commit (registered, visible the clk after the stop-sample tick):
  - If rx_full=0, or rx_ack=1 in the same cycle: load rx_data, set rx_full=1, pulse rx_valid. overrun is unchanged.
  - If rx_full=1 and rx_ack=0: set overrun=1. rx_data, rx_full and rx_valid are unchanged; the new byte is dropped.
- rx_ack:
  - Clears rx_full and overrun unless a commit occurs in the same cycle (commit wins for rx_full).
  - Ignored when rx_full=0.
- Latency: rx_valid rises one clk after the tick that samples the stop bit, i.e. about 9.5 bit times after the start edge.
- Sampling points: mid-bit, at ticks 8, 24, ... after start detection (OS_RATE=16).
- Timing tolerance: a tick-rate mismatch up to ±3% must decode correctly.
- Out of scope: no parity, no FIFO.

Test Plan:
- Single frame: baud_tick every 4 clks, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> one rx_valid pulse, rx_data=0xA5, rx_full=1, frame_err=0, overrun=0; rx_ack then gives rx_full=0.
- Back-to-back: send 0x00 then 0xFF with no idle gap, acking after each rx_valid -> rx_data=0x00, then 0xFF; exactly 2 rx_valid pulses; no errors.
- Glitch rejection: rx_in low for 5 ticks, then high -> no rx_valid and no frame_err; rx_busy high only during those ticks, then back to IDLE.
- Framing error and break: send 0x3C with the stop bit 0, then hold the line low 40 bit times, then high, then send 0x11 -> one frame_err pulse, rx_full stays 0, next frame gives rx_data=0x11.
- Overrun and simultaneous ack:
  - Receive 0x12 with no ack, then 0x34 -> overrun=1, rx_data stays 0x12.
  - Ack -> overrun=0, rx_full=0.
  - Receive 0x56 with rx_ack asserted in the commit cycle -> rx_data=0x56, rx_full=1, overrun=0.
- Reset mid-frame: assert reset during data bit 3 of 0x77 -> all outputs 0 immediately; after release, a fresh 0x81 is received correctly.
